correction_multi_u: RTL and testbench
=====================================

# correction_multi_u

Multi-step final correction stage for Montgomery reduction with moduli of the form q = qH·2^R + 1, R = LOGQ − LOGQH. It reduces an operand bounded by 2^LOGK·q into [0, q) using LOGK conditional-subtraction stages, largest multiple first. It sits after lazy-reduction accumulators in the modular-multiplier datapath. Compared with the single-step corrector, it adds:
- a valid/ready pipeline with backpressure;
- a run-time loadable qH with safe pipeline drain;
- an out-of-range flag.

## Interface
- LOGQ, 64, modulus/result width
- LOGQH, 17, width of qH; LOGQH ≤ LOGQ
- LOGK, 2, input bound exponent: C < 2^LOGK·q; legal range 1..4
- FF_IN, 1, register the input
- FF_STG, 1, register after each subtraction stage
- FF_OUT, 1, register the output
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  C valid
- in_ready  out  1  C accepted when in_valid && in_ready
- C  in  LOGQ+LOGK  operand
- out_valid  out  1  T/err valid
- out_ready  in  1  downstream accepts
- T  out  LOGQ  result
- err  out  1  C ≥ 2^LOGK·q
- qH_ld  in  1  request modulus update (level, held until qH_done)
- qH_in  in  LOGQH  new qH
- qH_done  out  1  one-cycle pulse: qH_in written

## Operation
- Working modulus register qH_q. The value q is {qH_q, (R−1) zeros, 1}, or qH_q alone when R = 0.
- Datapath width W = LOGQ+LOGK+1 (one guard bit for the sign).
- Stage j, for j = LOGK−1 down to 0:
  - D = V − (q << j);
  - V ← D if D is non-negative (guard bit 0), else V unchanged.
- Error check: a final trial subtraction of q. err = 1 iff the residue is still ≥ q. In that case T = residue[LOGQ−1:0], which is not reduced.
- Each register position carries a valid bit. Data registers need no reset; valid bits reset to 0.
- Advance enable: en = !out_valid || out_ready. All pipeline registers load only when en. Bubbles collapse only through en; there is no per-stage bubble squeeze.
- in_ready = en && (state == RUN).
- State machine:
  - RUN: normal operation. On qH_ld go to DRAIN; in_ready drops in the same cycle.
  - DRAIN: in_ready = 0. Pipeline flushes as downstream accepts. When all stage valid bits and out_valid are 0, go to LOAD.
  - LOAD: qH_q ← qH_in, pulse qH_done, return to RUN.
- Every in-flight word completes with the qH value that was current at its acceptance.
- If the design is fully combinational (all FF_* = 0), DRAIN lasts 0 cycles. LOAD still takes one cycle.
- qH_ld deasserted during DRAIN: the load still completes (the request is latched).

## Timing
- Latency L = FF_IN + LOGK·FF_STG + FF_OUT cycles from acceptance to out_valid. With L = 0, out_valid = in_valid combinationally.
- Throughput: 1 word/cycle while out_ready = 1.
- With out_ready = 0 and out_valid = 1:
  - T and err are held stable;
  - in_ready = 0 in the same cycle (registered configurations).
- Reset values:
  - out_valid = 0, qH_done = 0;
  - in_ready = 1 once rst is released (state RUN);
  - qH_q = 0 (q = 1 for R > 0);
  - T and err are don't-care while out_valid = 0.
- Reset asserted mid-operation: all valid bits clear immediately. In-flight words are discarded, not delivered. A pending load is abandoned and qH_q returns to 0.
- qH_ld arriving in the same cycle as an accepted input: the input is accepted. DRAIN starts next cycle.

## Structure
- Shared package correction_multi_u_pkg:
  - params struct {FF_IN, FF_STG, FF_OUT, LOGK};
  - function correction_multi_u_lat(params) returning L;
  - state enum {RUN, DRAIN, LOAD}.
- Sub-module cond_sub_stage:
  - parameters W, SHIFT, FF;
  - carries data plus valid, enabled by en;
  - instantiated LOGK times via generate.
- The final error compare is a further cond_sub_stage with SHIFT = 0, FF = 0, using only the sign bit.

## Test plan
Configuration for all scenarios: LOGQ = 8, LOGQH = 4, LOGK = 2, all FF = 1 (L = 4), qH = 0xB loaded first, so q = 177.
- Reset then load: rst low 2 cycles, then qH_ld with qH_in = 0xB → qH_done pulses once; in_ready = 1 afterwards.
- Reduction values:
  - C = 0 → T = 0;
  - C = 176 → T = 176;
  - C = 177 → T = 0;
  - C = 707 → T = 176.
  - Each with err = 0, valid exactly 4 cycles after acceptance.
- Out of range: C = 708 → err = 1, T = 177; C = 1023 → err = 1.
- Back-to-back stream of 20 random C < 708 with out_ready low for cycles 5–7:
  - outputs match C mod 177 in order;
  - no loss or duplication;
  - T stable while stalled.
- qH_ld mid-stream:
  - in_ready drops;
  - the 3 in-flight words complete with q = 177;
  - qH_done pulses after the last one;
  - with qH_in = 0x3 (q = 49), the next word C = 100 → T = 2.
- rst asserted with 3 words in flight → out_valid = 0 in the same cycle; none of those words ever appear.

Source files
------------

// File: rtl/correction_multi_u_pkg.sv
// Shared types for the multi-step Montgomery final-correction stage:
// pipeline configuration record, latency helper and control states.
package correction_multi_u_pkg;

    typedef struct packed {
        logic       ff_in;
        logic       ff_stg;
        logic       ff_out;
        logic [2:0] logk;
    } cmu_params_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        LOAD
    } cmu_state_t;

    function automatic int unsigned correction_multi_u_lat(input cmu_params_t p);
        int unsigned lat;
        lat = 32'(p.ff_in) + 32'(p.ff_out);
        if (p.ff_stg) begin
            lat = lat + 32'(p.logk);
        end
        return lat;
    endfunction

endpackage

// File: rtl/cond_sub_stage.sv
// One conditional-subtraction step: V <- V - (q << SHIFT) when the result is
// non-negative, optionally registered together with its valid bit.
module cond_sub_stage
    import correction_multi_u_pkg::*;
#(
    parameter int unsigned W     = 11,
    parameter int unsigned SHIFT = 0,
    parameter bit          FF    = 1'b1,
    parameter bit          UPD   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] q,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_take
);

    logic [W-1:0] diff;
    logic [W-1:0] nxt;
    logic         ok;

    assign diff = in_data - (q << SHIFT);
    assign ok   = !diff[W-1];
    // UPD = 0 turns the stage into a pure compare: data passes through untouched.
    assign nxt  = (UPD && ok) ? diff : in_data;

    if (FF) begin : g_reg
        logic         v_q;
        logic [W-1:0] d_q;
        logic         t_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= 1'b0;
            end else if (en) begin
                v_q <= in_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                d_q <= nxt;
                t_q <= ok;
            end
        end

        assign out_valid = v_q;
        assign out_data  = d_q;
        assign out_take  = t_q;
    end else begin : g_comb
        logic unused_ctl;
        assign unused_ctl = clk ^ rst ^ en;
        assign out_valid  = in_valid;
        assign out_data   = nxt;
        assign out_take   = ok;
    end

endmodule

// File: rtl/correction_multi_u.sv
// Reduces C < 2^LOGK * q into [0, q) through LOGK conditional subtractions,
// with valid/ready flow control and a drain-then-load modulus update.
module correction_multi_u
    import correction_multi_u_pkg::*;
#(
    parameter int unsigned LOGQ   = 64,
    parameter int unsigned LOGQH  = 17,
    parameter int unsigned LOGK   = 2,
    parameter bit          FF_IN  = 1'b1,
    parameter bit          FF_STG = 1'b1,
    parameter bit          FF_OUT = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LOGQ+LOGK-1:0] C,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LOGQ-1:0]      T,
    output logic                 err,
    input  logic                 qH_ld,
    input  logic [LOGQH-1:0]     qH_in,
    output logic                 qH_done
);

    localparam int unsigned W = LOGQ + LOGK + 1;
    localparam int unsigned R = LOGQ - LOGQH;
    localparam cmu_params_t P = '{ff_in: FF_IN, ff_stg: FF_STG, ff_out: FF_OUT, logk: 3'(LOGK)};
    localparam int unsigned LAT = correction_multi_u_lat(P);

    cmu_state_t       state, state_nxt;
    logic [LOGQH-1:0] qh_q;
    logic [W-1:0]     q;
    logic             en;
    logic             busy;
    logic             in_take;

    // Index 0 is the input position, 1..LOGK the subtraction stages,
    // LOGK+1 the final range compare.
    logic [W-1:0]  sd [LOGK+2];
    logic [LOGK+1:0] sv;
    logic [LOGK:0]   take;
    logic            unused_bits;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && (state == RUN);
    assign in_take  = in_valid && (state == RUN);
    assign q        = (W'(qh_q) << R) | W'(R > 0);
    assign busy     = (|sv) || out_valid;

    if (FF_IN) begin : g_in_ff
        logic         v_q;
        logic [W-1:0] d_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= 1'b0;
            end else if (en) begin
                v_q <= in_take;
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                d_q <= W'(C);
            end
        end

        assign sv[0] = v_q;
        assign sd[0] = d_q;
    end else begin : g_in_comb
        assign sv[0] = in_take;
        assign sd[0] = W'(C);
    end

    for (genvar i = 0; i < LOGK; i++) begin : g_stg
        cond_sub_stage #(
            .W    (W),
            .SHIFT(LOGK - 1 - i),
            .FF   (FF_STG),
            .UPD  (1'b1)
        ) u_stg (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .in_valid (sv[i]),
            .in_data  (sd[i]),
            .q        (q),
            .out_valid(sv[i+1]),
            .out_data (sd[i+1]),
            .out_take (take[i])
        );
    end

    cond_sub_stage #(
        .W    (W),
        .SHIFT(0),
        .FF   (1'b0),
        .UPD  (1'b0)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (sv[LOGK]),
        .in_data  (sd[LOGK]),
        .q        (q),
        .out_valid(sv[LOGK+1]),
        .out_data (sd[LOGK+1]),
        .out_take (take[LOGK])
    );

    assign unused_bits = ^{take[LOGK-1:0], sd[LOGK+1][W-1:LOGQ]};

    if (FF_OUT) begin : g_out_ff
        logic            v_q;
        logic [LOGQ-1:0] t_q;
        logic            e_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                v_q <= 1'b0;
            end else if (en) begin
                v_q <= sv[LOGK+1];
            end
        end

        always_ff @(posedge clk) begin
            if (en) begin
                t_q <= sd[LOGK+1][LOGQ-1:0];
                e_q <= take[LOGK];
            end
        end

        assign out_valid = v_q;
        assign T         = t_q;
        assign err       = e_q;
    end else begin : g_out_comb
        assign out_valid = sv[LOGK+1];
        assign T         = sd[LOGK+1][LOGQ-1:0];
        assign err       = take[LOGK];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            qh_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == LOAD) begin
                qh_q <= qH_in;
            end
        end
    end

    // A purely combinational datapath holds nothing in flight, so it skips DRAIN.
    always_comb begin
        state_nxt = state;
        qH_done   = 1'b0;
        case (state)
            RUN: begin
                if (qH_ld) begin
                    state_nxt = (LAT == 0) ? LOAD : DRAIN;
                end
            end
            DRAIN: begin
                if (!busy) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                qH_done   = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_correction_multi_u.sv
// Self-checking bench for correction_multi_u (LOGQ=8, LOGQH=4, LOGK=2, all stages registered).
module tb_correction_multi_u;

    localparam int LOGQ  = 8;
    localparam int LOGQH = 4;
    localparam int LOGK  = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [LOGQ+LOGK-1:0] C = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [LOGQ-1:0]      T;
    logic                 err;
    logic                 qH_ld = 1'b0;
    logic [LOGQH-1:0]     qH_in = '0;
    logic                 qH_done;

    always #5 clk = ~clk;

    correction_multi_u #(
        .LOGQ  (LOGQ),
        .LOGQH (LOGQH),
        .LOGK  (LOGK),
        .FF_IN (1'b1),
        .FF_STG(1'b1),
        .FF_OUT(1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .C        (C),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .T        (T),
        .err      (err),
        .qH_ld    (qH_ld),
        .qH_in    (qH_in),
        .qH_done  (qH_done)
    );

    typedef struct {
        int t;
        bit e;
        int acc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   model_q = 1;
    int   done_cnt = 0;
    int   out_cnt = 0;
    int   ov_seen = 0;
    int   last_lat = 0;
    bit   acc_flag = 1'b0;
    bit   stalled = 1'b0;
    logic [LOGQ-1:0] held_t;
    logic held_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference: the stages can remove at most 2^LOGK-1 multiples of q in total.
    function automatic void model(input int c, input int qv, output int t, output bit e);
        int m;
        int r;
        m = c / qv;
        if (m > (1 << LOGK) - 1) m = (1 << LOGK) - 1;
        r = c - m * qv;
        e = (r >= qv);
        t = r % (1 << LOGQ);
    endfunction

    task automatic tick();
        exp_t x;
        int   t;
        bit   e;
        #1;
        acc_flag = 1'b0;
        if (rst) begin
            if (out_valid) ov_seen++;
            if (stalled) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_T", T, held_t);
                check("stall_hold_err", err, held_e);
            end
            if (out_valid && !out_ready) begin
                check("stall_in_ready", in_ready, 0);
                held_t  = T;
                held_e  = err;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (qH_done) begin
                done_cnt++;
                model_q = int'(qH_in) * (1 << (LOGQ - LOGQH)) + 1;
            end
            if (in_valid && in_ready) begin
                model(int'(C), model_q, t, e);
                x.t = t;
                x.e = e;
                x.acc = cyc;
                exp_q.push_back(x);
                acc_flag = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 0);
                end else begin
                    x = exp_q.pop_front();
                    check("T", T, x.t);
                    check("err", err, x.e);
                    last_lat = cyc - x.acc;
                    out_cnt++;
                end
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic send_one(input int c);
        in_valid = 1'b1;
        C = 10'(c);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc_flag) break;
        end
        in_valid = 1'b0;
        C = '0;
    endtask

    task automatic wait_out(input string tag);
        int n0;
        n0 = out_cnt;
        for (int i = 0; i < 20 && out_cnt == n0; i++) tick();
        check({tag, "_delivered"}, out_cnt - n0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic load_qh(input logic [LOGQH-1:0] v);
        int start;
        start = done_cnt;
        qH_in = v;
        qH_ld = 1'b1;
        for (int i = 0; i < 40 && done_cnt == start; i++) tick();
        qH_ld = 1'b0;
        repeat (3) tick();
        check("load_pulses", done_cnt - start, 1);
        check("load_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int dir_c[6];
        int stream_c[20];
        int n;
        int n0;
        int d0;
        int g0;

        dir_c = '{0, 176, 177, 707, 708, 1023};
        for (int i = 0; i < 20; i++) stream_c[i] = int'($urandom_range(707, 0));

        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            #1;
            check("rst_out_valid", out_valid, 0);
            check("rst_qH_done", qH_done, 0);
            @(negedge clk);
        end
        rst = 1'b1;
        tick();
        check("in_ready_after_rst", in_ready, 1);

        load_qh(4'hB);

        for (int k = 0; k < 6; k++) begin
            send_one(dir_c[k]);
            wait_out("directed");
            check("latency", last_lat, 4);
        end

        n0 = out_cnt;
        n = 0;
        for (int s = 0; s < 200 && n < 20; s++) begin
            in_valid  = 1'b1;
            C         = 10'(stream_c[n]);
            out_ready = !(s >= 5 && s <= 7);
            tick();
            if (acc_flag) n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_accepted", n, 20);
        drain();
        check("stream_count", out_cnt - n0, 20);

        n0 = out_cnt;
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            C = 10'($urandom_range(707, 0));
            if (k == 2) begin
                qH_in = 4'h3;
                qH_ld = 1'b1;
            end
            tick();
            check("midstream_accept", acc_flag, 1);
        end
        C = 10'd100;
        check("drain_in_ready", in_ready, 0);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (qH_ld && done_cnt != d0) begin
                check("inflight_before_load", out_cnt - n0, 3);
                qH_ld = 1'b0;
            end
            if (acc_flag) break;
        end
        in_valid = 1'b0;
        drain();
        check("midstream_pulses", done_cnt - d0, 1);
        check("midstream_count", out_cnt - n0, 4);

        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            C = 10'($urandom_range(195, 0));
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && !out_valid; i++) tick();
        check("pre_rst_out_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        check("rst_midflight_out_valid", out_valid, 0);
        exp_q.delete();
        stalled = 1'b0;
        model_q = 1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        g0 = ov_seen;
        repeat (12) tick();
        check("no_ghost_words", ov_seen - g0, 0);

        send_one(5);
        wait_out("post_rst_q1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
